cocomemjr_dma: RTL and testbench

- Bus initiator on the CoCoMEMJr expansion memory: block copy inside the 2 MB on-board SRAM space.
- Halts the 6809 via _halt, waits for BA, then issues alternating read and write cycles clocked by e.
- Releases the bus when done.
- Complements the existing MMU/memory responder: the MMU answers CPU cycles; this block originates them.

---
 rtl/cocomemjr_pkg.sv | 16 +
 rtl/cocomemjr_dma_if.sv | 36 +++
 rtl/cocomemjr_dma_ba_sync.sv | 28 ++
 rtl/cocomemjr_dma.sv | 169 ++++++++++++++++
 tb/tb_cocomemjr_dma.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cocomemjr_pkg.sv
// Shared types and constants for the CoCoMEMJr DMA block.
package cocomemjr_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 21;
  localparam int unsigned LEN_WIDTH_DEF  = 16;
  localparam int unsigned SRAM_SIZE      = 32'h0020_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/cocomemjr_dma_if.sv
// Request/status handshake between a host controller and cocomemjr_dma.
// Fill ports exist only when COCOMEMJR_DMA_FILL_EN is defined.
interface cocomemjr_dma_if
  import cocomemjr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) ();

  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [LEN_WIDTH-1:0]  length;
`ifdef COCOMEMJR_DMA_FILL_EN
  logic                  fill;
  logic [7:0]            fill_value;
`endif
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic [LEN_WIDTH-1:0]  remaining;

`ifdef COCOMEMJR_DMA_FILL_EN
  modport master (output start, abort, src_addr, dst_addr, length, fill, fill_value,
                  input  busy, done, aborted, remaining);
  modport slave  (input  start, abort, src_addr, dst_addr, length, fill, fill_value,
                  output busy, done, aborted, remaining);
`else
  modport master (output start, abort, src_addr, dst_addr, length,
                  input  busy, done, aborted, remaining);
  modport slave  (input  start, abort, src_addr, dst_addr, length,
                  output busy, done, aborted, remaining);
`endif

endinterface

// File: rtl/cocomemjr_dma_ba_sync.sv
// Multi-stage synchroniser for the 6809 BA input (STAGES >= 1).
module dma_ba_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage per clock.
  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d;
  end

  // Synchroniser flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cocomemjr_dma.sv
// CoCoMEMJr SRAM block-copy initiator: halts the 6809, then alternates
// READ/WRITE cycles on e. Optional fill mode under COCOMEMJR_DMA_FILL_EN.
module cocomemjr_dma
  import cocomemjr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int unsigned BA_SYNC    = 2
) (
  input  logic                  e,
  input  logic                  reset,
  cocomemjr_dma_if.slave        ctl,
  input  logic                  ba,
  output logic                  _halt,
  output logic [ADDR_WIDTH-1:0] address_mem,
  inout  wire  [7:0]            data_mem,
  output logic                  _we_ram,
  output logic                  _oe_ram,
  output logic                  mem_owner
);

  dma_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [7:0]            data_q, data_d;
  logic                  halt_n_q, halt_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic                  owner_q, owner_d, dout_en_q, dout_en_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  aborted_q, aborted_d, abort_pend_q, abort_pend_d;
  logic                  fill_mode;
  logic                  ba_s;

`ifdef COCOMEMJR_DMA_FILL_EN
  logic fill_q, fill_d;
  assign fill_mode = fill_q;
`else
  assign fill_mode = 1'b0;
`endif

  dma_ba_sync #(.STAGES(BA_SYNC)) u_ba_sync (
    .clk (e),
    .rst (reset),
    .d   (ba),
    .q   (ba_s)
  );

  // Next state, counters and the bus outputs decoded from the next state.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    data_d       = data_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
`ifdef COCOMEMJR_DMA_FILL_EN
    fill_d       = fill_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (ctl.start) begin
          src_d        = ctl.src_addr;
          dst_d        = ctl.dst_addr;
          rem_d        = ctl.length;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
`ifdef COCOMEMJR_DMA_FILL_EN
          fill_d       = ctl.fill;
          if (ctl.fill) data_d = ctl.fill_value;
`endif
          state_d      = (ctl.length == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (ctl.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (ba_s) begin
          state_d = fill_mode ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        // Byte is captured here; an abort now still lets WRITE finish it.
        data_d  = data_mem;
        state_d = ST_WRITE;
        if (ctl.abort) abort_pend_d = 1'b1;
      end
      ST_WRITE: begin
        dst_d = dst_q + ADDR_WIDTH'(1);
        if (!fill_mode) src_d = src_q + ADDR_WIDTH'(1);
        rem_d = rem_q - LEN_WIDTH'(1);
        if (rem_q == LEN_WIDTH'(1) || ctl.abort || abort_pend_q) begin
          aborted_d = ctl.abort || abort_pend_q;
          state_d   = ST_DONE;
        end else begin
          state_d = fill_mode ? ST_WRITE : ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    halt_n_d  = !(state_d inside {ST_REQ, ST_READ, ST_WRITE});
    owner_d   = state_d inside {ST_READ, ST_WRITE};
    oe_n_d    = (state_d != ST_READ);
    we_n_d    = (state_d != ST_WRITE);
    dout_en_d = (state_d == ST_WRITE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_q == ST_DONE);
    addr_d    = (state_d == ST_READ)  ? src_d :
                (state_d == ST_WRITE) ? dst_d : '0;
  end

  // State and output registers; reset releases the bus at once.
  always_ff @(posedge e or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      halt_n_q     <= 1'b1;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      owner_q      <= 1'b0;
      dout_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
`ifdef COCOMEMJR_DMA_FILL_EN
      fill_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      halt_n_q     <= halt_n_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      owner_q      <= owner_d;
      dout_en_q    <= dout_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
`ifdef COCOMEMJR_DMA_FILL_EN
      fill_q       <= fill_d;
`endif
    end
  end

  assign _halt         = halt_n_q;
  assign _we_ram       = we_n_q;
  assign _oe_ram       = oe_n_q;
  assign mem_owner     = owner_q;
  assign address_mem   = addr_q;
  assign data_mem      = dout_en_q ? data_q : 8'hzz;
  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;
  assign ctl.aborted   = aborted_q;
  assign ctl.remaining = rem_q;

endmodule

// File: tb/tb_cocomemjr_dma.sv
// Self-checking bench for cocomemjr_dma: SRAM model, 6809 BA responder and a
// byte-level copy reference model. Fill test runs when COCOMEMJR_DMA_FILL_EN is set.
module tb_cocomemjr_dma;
  import cocomemjr_pkg::*;

  localparam int unsigned AW = ADDR_WIDTH_DEF;
  localparam int unsigned LW = LEN_WIDTH_DEF;

  logic          e = 1'b0;
  logic          reset;
  logic          ba;
  logic          _halt, _we_ram, _oe_ram, mem_owner;
  logic [AW-1:0] address_mem;
  wire  [7:0]    data_mem;

  cocomemjr_dma_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) ctl ();

  cocomemjr_dma dut (
    .e           (e),
    .reset       (reset),
    .ctl         (ctl),
    .ba          (ba),
    ._halt       (_halt),
    .address_mem (address_mem),
    .data_mem    (data_mem),
    ._we_ram     (_we_ram),
    ._oe_ram     (_oe_ram),
    .mem_owner   (mem_owner)
  );

  always #5 e = ~e;

  logic [7:0]    sram [0:SRAM_SIZE-1];
  logic [7:0]    refm [0:SRAM_SIZE-1];
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wr_q[$];
  int            wr_cyc[$];
  int            we_any, oe_any;
  int            n_chk = 0;
  int            n_fail = 0;

  // SRAM answers reads combinationally while output-enabled.
  assign data_mem = (!_oe_ram && _we_ram) ? sram[address_mem] : 8'hzz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe one bus cycle (called mid-cycle at the falling edge).
  task automatic sample(input int c);
    if (!_we_ram) we_any++;
    if (!_oe_ram) oe_any++;
    if (mem_owner) begin
      if (!_we_ram) begin
        sram[address_mem] = data_mem;
        wr_q.push_back(address_mem);
        wr_cyc.push_back(c);
      end
      if (!_oe_ram) rd_q.push_back(address_mem);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      sram[AW'(a + AW'(i))] = v;
      refm[AW'(a + AW'(i))] = v;
    end
  endtask

  // Reference: strictly ascending byte copy, addresses modulo the SRAM size.
  task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    for (int i = 0; i < n; i++)
      refm[AW'(d + AW'(i))] = refm[AW'(s + AW'(i))];
  endtask

  task automatic check_mem(input string tag, input logic [AW-1:0] d, input int n);
    for (int i = 0; i < n; i++)
      chk(tag, 32'(sram[AW'(d + AW'(i))]), 32'(refm[AW'(d + AW'(i))]));
  endtask

  task automatic xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] len,
                      input int ba_dly, input int abort_at, input bit fill, input logic [7:0] fval,
                      output int n_done, output int t_done, output bit halt_low);
    int hcnt, rd;
    rd_q.delete(); wr_q.delete(); wr_cyc.delete();
    we_any = 0; oe_any = 0; hcnt = 0; rd = 0;
    n_done = 0; t_done = -1; halt_low = 1'b0;
    @(negedge e);
    ctl.src_addr = s; ctl.dst_addr = d; ctl.length = len; ctl.start = 1'b1;
`ifdef COCOMEMJR_DMA_FILL_EN
    ctl.fill = fill; ctl.fill_value = fval;
`else
    if (fill || fval != 8'h00) $display("note: fill mode not built");
`endif
    @(posedge e); #1 ctl.start = 1'b0;
    for (int c = 0; c < 4 * int'(len) + 60 && t_done < 0; c++) begin
      @(negedge e);
      sample(c);
      if (!_halt) begin
        halt_low = 1'b1;
        if (!ba) begin hcnt++; if (hcnt >= ba_dly) ba = 1'b1; end
      end
      if (!_oe_ram) begin rd++; if (rd == abort_at) ctl.abort = 1'b1; end
      if (ctl.done) begin n_done++; t_done = c + 1; end
    end
    @(negedge e);
    sample(-1);
    if (ctl.done) n_done++;
    ba = 1'b0; ctl.abort = 1'b0;
  endtask

  initial begin
    int nd, td;
    bit hl;
    logic [AW-1:0] s, d;
    int len;
    reset = 1'b1; ba = 1'b0;
    ctl.start = 1'b0; ctl.abort = 1'b0; ctl.src_addr = '0; ctl.dst_addr = '0; ctl.length = '0;
`ifdef COCOMEMJR_DMA_FILL_EN
    ctl.fill = 1'b0; ctl.fill_value = 8'h00;
`endif
    repeat (2) @(posedge e);
    @(negedge e);
    chk("rst_halt", 32'(_halt), 32'd1);
    chk("rst_we", 32'(_we_ram), 32'd1);
    chk("rst_oe", 32'(_oe_ram), 32'd1);
    chk("rst_owner", 32'(mem_owner), 32'd0);
    chk("rst_busy", 32'(ctl.busy), 32'd0);
    chk("rst_done", 32'(ctl.done), 32'd0);
    chk("rst_aborted", 32'(ctl.aborted), 32'd0);
    chk("rst_remaining", 32'(ctl.remaining), 32'd0);
    chk("rst_addr", 32'(address_mem), 32'd0);
    chk("rst_drive", 32'(dut.dout_en_q), 32'd0);
    reset = 1'b0;

    // Basic copy of four known bytes.
    s = AW'(32'h010000); d = AW'(32'h020000);
    poke(d, 4);
    sram[s] = 8'h11; sram[s + 1] = 8'h22; sram[s + 2] = 8'h33; sram[s + 3] = 8'h44;
    refm[s] = 8'h11; refm[s + 1] = 8'h22; refm[s + 2] = 8'h33; refm[s + 3] = 8'h44;
    xfer(s, d, LW'(4), 3, 0, 1'b0, 8'h00, nd, td, hl);
    chk("basic_b0", 32'(sram[d]), 32'h11);
    chk("basic_b1", 32'(sram[d + 1]), 32'h22);
    chk("basic_b2", 32'(sram[d + 2]), 32'h33);
    chk("basic_b3", 32'(sram[d + 3]), 32'h44);
    chk("basic_writes", 32'(wr_q.size()), 32'd4);
    chk("basic_reads", 32'(rd_q.size()), 32'd4);
    chk("basic_done", 32'(nd), 32'd1);
    chk("basic_halt", 32'(_halt), 32'd1);
    chk("basic_remaining", 32'(ctl.remaining), 32'd0);

    // Zero length: no halt, no strobe, done two cycles after start.
    xfer(AW'(32'h000200), AW'(32'h000300), LW'(0), 1, 0, 1'b0, 8'h00, nd, td, hl);
    chk("zero_halt_low", 32'(hl), 32'd0);
    chk("zero_done_lat", 32'(td), 32'd2);
    chk("zero_done_cnt", 32'(nd), 32'd1);
    chk("zero_we", 32'(we_any), 32'd0);

    // Source address wraps past the top of the SRAM.
    s = AW'(32'h1FFFFE); d = AW'(32'h000100);
    poke(s, 4); poke(d, 4); model_copy(s, d, 4);
    xfer(s, d, LW'(4), 2, 0, 1'b0, 8'h00, nd, td, hl);
    chk("wrap_reads", 32'(rd_q.size()), 32'd4);
    if (rd_q.size() == 4) begin
      chk("wrap_rd0", 32'(rd_q[0]), 32'h1FFFFE);
      chk("wrap_rd1", 32'(rd_q[1]), 32'h1FFFFF);
      chk("wrap_rd2", 32'(rd_q[2]), 32'h000000);
      chk("wrap_rd3", 32'(rd_q[3]), 32'h000001);
    end
    chk("wrap_writes", 32'(wr_q.size()), 32'd4);
    if (wr_q.size() == 4) chk("wrap_wr3", 32'(wr_q[3]), 32'h000103);
    check_mem("wrap_data", d, 4);

    // Abort during the third READ: that byte still lands, then stop.
    s = AW'(32'h070000); d = AW'(32'h080000);
    poke(s, 4); poke(d, 4); model_copy(s, d, 3);
    xfer(s, d, LW'(100), 3, 3, 1'b0, 8'h00, nd, td, hl);
    check_mem("abort_data", d, 4);
    chk("abort_writes", 32'(wr_q.size()), 32'd3);
    chk("abort_flag", 32'(ctl.aborted), 32'd1);
    chk("abort_remaining", 32'(ctl.remaining), 32'd97);
    chk("abort_halt", 32'(_halt), 32'd1);
    chk("abort_done", 32'(nd), 32'd1);

    // Randomised copies, including overlapping ascending regions.
    for (int k = 0; k < 6; k++) begin
      s   = AW'($urandom_range(0, SRAM_SIZE - 1));
      d   = (k % 2 == 0) ? AW'($urandom_range(0, SRAM_SIZE - 1)) : AW'(s + AW'($urandom_range(1, 3)));
      len = int'($urandom_range(1, 10));
      poke(s, len); poke(d, len); model_copy(s, d, len);
      xfer(s, d, LW'(len), int'($urandom_range(1, 4)), 0, 1'b0, 8'h00, nd, td, hl);
      check_mem("rand_data", d, len);
      chk("rand_writes", 32'(wr_q.size()), 32'(len));
      chk("rand_reads", 32'(rd_q.size()), 32'(len));
      if (rd_q.size() > 0) chk("rand_rd_last", 32'(rd_q[rd_q.size() - 1]), 32'(AW'(s + AW'(len - 1))));
      chk("rand_done", 32'(nd), 32'd1);
      chk("rand_aborted", 32'(ctl.aborted), 32'd0);
      chk("rand_remaining", 32'(ctl.remaining), 32'd0);
    end

    // Reset in the middle of a WRITE cycle.
    begin
      bit hit;
      int hc;
      hit = 1'b0; hc = 0;
      @(negedge e);
      ctl.src_addr = AW'(32'h050000); ctl.dst_addr = AW'(32'h060000); ctl.length = LW'(10);
      ctl.start = 1'b1;
      @(posedge e); #1 ctl.start = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
        @(negedge e);
        if (!_halt && !ba) begin hc++; if (hc >= 2) ba = 1'b1; end
        if (!_we_ram) hit = 1'b1;
      end
      chk("rstw_reached", 32'(hit), 32'd1);
      reset = 1'b1;
      #1;
      chk("rstw_we", 32'(_we_ram), 32'd1);
      chk("rstw_halt", 32'(_halt), 32'd1);
      chk("rstw_drive", 32'(dut.dout_en_q), 32'd0);
      chk("rstw_busy", 32'(ctl.busy), 32'd0);
      chk("rstw_owner", 32'(mem_owner), 32'd0);
      ba = 1'b0;
      @(negedge e);
      reset = 1'b0;
    end
    s = AW'(32'h0A0000); d = AW'(32'h0B0000);
    poke(s, 2); poke(d, 2); model_copy(s, d, 1);
    xfer(s, d, LW'(1), 2, 0, 1'b0, 8'h00, nd, td, hl);
    check_mem("post_rst_data", d, 2);
    chk("post_rst_done", 32'(nd), 32'd1);
    chk("post_rst_remaining", 32'(ctl.remaining), 32'd0);

`ifdef COCOMEMJR_DMA_FILL_EN
    // Fill: consecutive WRITEs, no reads.
    d = AW'(32'h030000);
    poke(d, 9);
    for (int i = 0; i < 8; i++) refm[d + AW'(i)] = 8'hA5;
    xfer(AW'(32'h000000), d, LW'(8), 2, 0, 1'b1, 8'hA5, nd, td, hl);
    check_mem("fill_data", d, 9);
    chk("fill_writes", 32'(wr_q.size()), 32'd8);
    if (wr_cyc.size() == 8) chk("fill_consecutive", 32'(wr_cyc[7] - wr_cyc[0]), 32'd7);
    chk("fill_oe", 32'(oe_any), 32'd0);
    chk("fill_done", 32'(nd), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
